updown_counter_p: RTL and testbench
===================================

UPDOWN_COUNTER_P -- requirements
Module: updown_counter_p

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter/load/limit bit width (legal range 2..32).
REQ-002 The block SHALL have parameter RST_LIMIT, default all-ones of WIDTH, reset value of the limit register.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; count steps once per cycle while high.
REQ-006 dir  input  1  count direction; 1 = up, 0 = down.
REQ-007 mode_sat  input  1  boundary mode; 0 = wrap, 1 = saturate.
REQ-008 load_en  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value written to count on load.
REQ-010 limit_we  input  1  limit register write strobe.
REQ-011 limit_val  input  WIDTH  new limit value.
REQ-012 clr_flag  input  1  clears sticky overflow flag.
REQ-013 oe  input  1  output enable for output_val.
REQ-014 output_val  output  WIDTH  count value when oe high, else all zeros (combinational gate on registered count).
REQ-015 tc  output  1  registered one-cycle terminal-count pulse.
REQ-016 ovf  output  1  registered sticky boundary-event flag.

Function
REQ-017 Count update priority per cycle SHALL be: load_en (count <= load_val), else en (step), else hold.
REQ-018 Load SHALL accept any load_val, including values above limit; load SHALL NOT assert tc nor set ovf.
REQ-019 Up step, count < limit: count <= count + 1.
REQ-020 Up step, count >= limit: wrap mode count <= 0; saturate mode count <= limit; both are a boundary event.
REQ-021 Down step, count > 0 and count <= limit: count <= count - 1.
REQ-022 Down step, count == 0: wrap mode count <= limit; saturate mode count holds 0; both are a boundary event.
REQ-023 Down step, count > limit (after over-limit load): count <= limit, no boundary event.
REQ-024 A boundary event SHALL assert tc for exactly the one cycle following the event edge; consecutive saturated steps SHALL produce tc every cycle.
REQ-025 A boundary event SHALL set ovf on the same edge tc is registered; ovf SHALL stay high until clr_flag.
REQ-026 clr_flag and a boundary event in the same cycle SHALL leave ovf set (set wins).
REQ-027 limit_we SHALL update limit on the rising edge; the step in that same cycle SHALL use the old limit.
REQ-028 limit_we with limit_val == 0 SHALL be legal: up steps then produce a boundary event every cycle.
REQ-029 oe SHALL affect only output_val; count, tc, ovf evolve independently of oe.
REQ-030 All arithmetic SHALL be WIDTH bits unsigned; no intermediate result wider than WIDTH+1 bits SHALL reach a register.

Reset
REQ-031 rst_n low SHALL immediately (no clock needed) force count = 0, limit = RST_LIMIT, tc = 0, ovf = 0.
REQ-032 rst_n low mid-count or mid-load SHALL discard the pending operation; first update after deassertion occurs on the first rising edge with rst_n high.
REQ-033 output_val during reset SHALL be 0 regardless of oe.

Verification (WIDTH=8)
REQ-034 Reset, en=1, dir=1, mode_sat=0, oe=1, limit=255, 256 cycles -> output_val 0..255 then 0; tc high exactly one cycle after 255->0; ovf=1.
REQ-035 limit_we with limit_val=9, mode_sat=1, dir=1 from 0, 12 cycles -> count 0..9 then holds 9; tc high on each saturated cycle; clr_flag coincident with tc -> ovf stays 1.
REQ-036 load_en with load_val=3 and en=1 simultaneously -> count=3 next cycle, tc=0; then dir=0, mode_sat=0, limit=9, 4 steps -> 2,1,0,9, tc one cycle after 0->9.
REQ-037 limit=9, load_val=200, dir=0 step -> count=9, tc=0, ovf unchanged; dir=1 step from 200 -> wrap to 0, tc=1.
REQ-038 oe=0 while counting 0..5 -> output_val=0 throughout; oe=1 -> output_val=current count immediately.
REQ-039 rst_n asserted asynchronously between edges at count=77, ovf=1 -> count, tc, ovf, output_val read 0 before next edge; limit returns to 255.

Source files
------------

// File: rtl/updown_counter_p.sv
// Up/down counter with runtime limit, wrap or saturate boundary handling,
// registered terminal-count pulse, sticky overflow flag and gated output.
module updown_counter_p #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RST_LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode_sat,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             limit_we,
  input  logic [WIDTH-1:0] limit_val,
  input  logic             clr_flag,
  input  logic             oe,
  output logic [WIDTH-1:0] output_val,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    count_d  = count_q;
    boundary = 1'b0;
    if (load_en) begin
      count_d = load_val;
    end else if (en) begin
      if (dir) begin
        if (count_q < limit_q) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          // At or above the limit (above only after an over-limit load).
          boundary = 1'b1;
          count_d  = mode_sat ? limit_q : '0;
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = mode_sat ? '0 : limit_q;
        end else if (count_q > limit_q) begin
          // Pull an over-limit value back into range without flagging an event.
          count_d = limit_q;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end

    // The step above already used the old limit_q, so a same-cycle write only takes effect next cycle.
    limit_d = limit_we ? limit_val : limit_q;
    tc_d    = boundary;
    ovf_d   = boundary | (ovf_q & ~clr_flag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= RST_LIMIT;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, matching flop behaviour.
      count_q <= count_d;
      limit_q <= limit_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign output_val = oe ? count_q : '0;
  assign tc         = tc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_updown_counter_p.sv
// Directed, table-driven bench for updown_counter_p at WIDTH=8.
module tb_updown_counter_p;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, dir, mode_sat, load_en, limit_we, clr_flag, oe;
  logic [W-1:0] load_val, limit_val;
  logic [W-1:0] output_val;
  logic         tc, ovf;

  int checks = 0;
  int errors = 0;

  updown_counter_p #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dir       (dir),
    .mode_sat  (mode_sat),
    .load_en   (load_en),
    .load_val  (load_val),
    .limit_we  (limit_we),
    .limit_val (limit_val),
    .clr_flag  (clr_flag),
    .oe        (oe),
    .output_val(output_val),
    .tc        (tc),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         load_en;
    logic [W-1:0] load_val;
    logic         en;
    logic         dir;
    logic         sat;
    logic         lwe;
    logic [W-1:0] lval;
    logic         clr;
    logic         oe;
    logic [W-1:0] e_cnt;
    logic         e_tc;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t v(input string name, input logic ld, input logic [W-1:0] lv,
                             input logic e, input logic d, input logic s,
                             input logic lwe, input logic [W-1:0] lval, input logic clr,
                             input logic o, input logic [W-1:0] ec, input logic et,
                             input logic eo);
    vec_t r;
    r.name = name; r.load_en = ld; r.load_val = lv; r.en = e; r.dir = d; r.sat = s;
    r.lwe = lwe; r.lval = lval; r.clr = clr; r.oe = o;
    r.e_cnt = ec; r.e_tc = et; r.e_ovf = eo;
    return r;
  endfunction

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic e, input logic d,
                       input logic s, input logic lwe, input logic [W-1:0] lval,
                       input logic clr, input logic o);
    load_en = ld; load_val = lv; en = e; dir = d; mode_sat = s;
    limit_we = lwe; limit_val = lval; clr_flag = clr; oe = o;
  endtask

  task automatic apply(input vec_t x);
    drive(x.load_en, x.load_val, x.en, x.dir, x.sat, x.lwe, x.lval, x.clr, x.oe);
    @(posedge clk);
    #1;
    check({x.name, ".out"}, output_val, x.oe ? x.e_cnt : '0);
    check({x.name, ".tc"},  tc,  x.e_tc);
    check({x.name, ".ovf"}, ovf, x.e_ovf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 1, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("reset.out", output_val, 0);
    check("reset.tc",  tc, 0);
    check("reset.ovf", ovf, 0);
    oe = 1'b0;
    #1 check("reset.out_oe0", output_val, 0);
    oe = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full wrap sweep with the reset limit of 255.
    drive(0, 0, 1, 1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      check("sweep.out", output_val, k % 256);
      check("sweep.tc",  tc, (k == 256));
      check("sweep.ovf", ovf, (k == 256));
    end

    //           name            ld lv   en dir sat lwe lval clr oe  cnt tc ovf
    vecs.push_back(v("sweep_end",  0, 0,   0, 1, 0,  0, 0,   0,  1,  0, 0, 1));
    vecs.push_back(v("clr_ovf",    0, 0,   0, 1, 0,  0, 0,   1,  1,  0, 0, 0));
    vecs.push_back(v("lim9",       0, 0,   0, 1, 1,  1, 9,   0,  1,  0, 0, 0));
    for (int k = 1; k <= 9; k++)
      vecs.push_back(v("sat_up",   0, 0,   1, 1, 1,  0, 0,   0,  1,  W'(k), 0, 0));
    vecs.push_back(v("sat_hold1",  0, 0,   1, 1, 1,  0, 0,   0,  1,  9, 1, 1));
    vecs.push_back(v("sat_hold2",  0, 0,   1, 1, 1,  0, 0,   0,  1,  9, 1, 1));
    vecs.push_back(v("sat_clr",    0, 0,   1, 1, 1,  0, 0,   1,  1,  9, 1, 1));
    vecs.push_back(v("sat_idle",   0, 0,   0, 1, 1,  0, 0,   1,  1,  9, 0, 0));
    vecs.push_back(v("old_limit",  0, 0,   1, 1, 1,  1, 20,  0,  1,  9, 1, 1));
    vecs.push_back(v("new_limit",  0, 0,   1, 1, 1,  0, 0,   0,  1, 10, 0, 1));
    vecs.push_back(v("lim9_again", 0, 0,   0, 1, 0,  1, 9,   1,  1, 10, 0, 0));
    vecs.push_back(v("load_en3",   1, 3,   1, 1, 0,  0, 0,   0,  1,  3, 0, 0));
    vecs.push_back(v("down2",      0, 0,   1, 0, 0,  0, 0,   0,  1,  2, 0, 0));
    vecs.push_back(v("down1",      0, 0,   1, 0, 0,  0, 0,   0,  1,  1, 0, 0));
    vecs.push_back(v("down0",      0, 0,   1, 0, 0,  0, 0,   0,  1,  0, 0, 0));
    vecs.push_back(v("down_wrap",  0, 0,   1, 0, 0,  0, 0,   0,  1,  9, 1, 1));
    vecs.push_back(v("down_idle",  0, 0,   0, 0, 0,  0, 0,   1,  1,  9, 0, 0));
    vecs.push_back(v("load200",    1, 200, 0, 0, 0,  0, 0,   0,  1, 200, 0, 0));
    vecs.push_back(v("down_over",  0, 0,   1, 0, 0,  0, 0,   0,  1,  9, 0, 0));
    vecs.push_back(v("load200b",   1, 200, 0, 1, 0,  0, 0,   0,  1, 200, 0, 0));
    vecs.push_back(v("up_over",    0, 0,   1, 1, 0,  0, 0,   0,  1,  0, 1, 1));
    vecs.push_back(v("load_at_bd", 1, 9,   1, 1, 0,  0, 0,   1,  1,  9, 0, 0));
    vecs.push_back(v("load_no_tc", 1, 9,   1, 1, 0,  0, 0,   0,  1,  9, 0, 0));
    vecs.push_back(v("lim0",       1, 0,   0, 1, 0,  1, 0,   0,  1,  0, 0, 0));
    vecs.push_back(v("lim0_up1",   0, 0,   1, 1, 0,  0, 0,   0,  1,  0, 1, 1));
    vecs.push_back(v("lim0_up2",   0, 0,   1, 1, 0,  0, 0,   1,  1,  0, 1, 1));
    vecs.push_back(v("sat_dn0",    0, 0,   1, 0, 1,  0, 0,   0,  1,  0, 1, 1));
    vecs.push_back(v("lim255",     0, 0,   0, 1, 0,  1, 255, 1,  1,  0, 0, 0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(v("oe_off",   0, 0,   1, 1, 0,  0, 0,   0,  0,  W'(k), 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // oe is a purely combinational gate: no edge needed to see the count.
    oe = 1'b1;
    en = 1'b0;
    #1 check("oe_on.out", output_val, 5);

    // Build up count=77 with ovf set under limit 9, then reset between edges.
    @(posedge clk); #1;
    drive(1, 255, 0, 1, 0, 1, 9, 0, 1);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("pre_rst.ovf", ovf, 1);
    drive(1, 77, 0, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("pre_rst.out", output_val, 77);
    drive(1, 123, 1, 1, 0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.out", output_val, 0);
    check("async_rst.tc",  tc, 0);
    check("async_rst.ovf", ovf, 0);
    @(posedge clk); #2;
    check("in_rst.out", output_val, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst.out", output_val, 1);
    // Limit is back at 255: 254 -> 255 is a plain step, 255 -> 0 is the boundary.
    drive(1, 254, 0, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("rst_lim.out", output_val, 255);
    check("rst_lim.tc",  tc, 0);
    @(posedge clk); #1;
    check("rst_lim_wrap.out", output_val, 0);
    check("rst_lim_wrap.tc",  tc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
